bootram_loader: RTL and testbench

Upstream feeder for the 16-bit boot/program dual-port RAM.
- Accepts a byte stream (valid/ready) from the debug/UART download path.
- Packs bytes little-endian into 16-bit words and writes them through RAM port A from a programmable base address.
- Keeps a running word checksum and reports busy/done/error to the system control register map.

---
 rtl/bootram_pkg.sv | 22 ++
 rtl/bootram_loader_if.sv | 29 ++
 rtl/bootram_pack16.sv | 36 +++
 rtl/bootram_loader.sv | 140 ++++++++++++++
 tb/tb_bootram_loader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bootram_pkg.sv
// Shared types and sizing for the boot RAM loader: state encoding, RAM geometry,
// and the byte/word types used on the stream and RAM sides.
package bootram_pkg;

    localparam int BOOTRAM_DATA = 16;
    localparam int BOOTRAM_ADDR = 13;

    typedef logic [7:0]              byte_t;
    typedef logic [BOOTRAM_DATA-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WRITE,
        VERIFY,
        CHECK,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/bootram_loader_if.sv
// Byte stream in and RAM port A out of the boot loader; master is the loader side,
// slave is the stream source plus RAM.
interface bootram_loader_if
    import bootram_pkg::*;
#(
    parameter int ADDR = BOOTRAM_ADDR,
    parameter int DATA = BOOTRAM_DATA
) ();

    byte_t           s_data;
    logic            s_valid;
    logic            s_ready;
    logic            ram_ce;
    logic            ram_we;
    logic [ADDR-1:0] ram_addr;
    logic [DATA-1:0] ram_wdata;
    logic [DATA-1:0] ram_rdata;

    modport master (
        input  s_data, s_valid, ram_rdata,
        output s_ready, ram_ce, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output s_data, s_valid, ram_rdata,
        input  s_ready, ram_ce, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/bootram_pack16.sv
// Little-endian byte-to-word packer: first accepted byte is the low half; word_vld
// flags the cycle whose accepted byte completes the word.
module bootram_pack16
    import bootram_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  clear,
    input  logic  take,
    input  byte_t din,
    output word_t word,
    output logic  word_vld
);

    logic  phase_hi;
    byte_t lo_q;
    byte_t hi_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_hi <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else if (clear) begin
            phase_hi <= 1'b0;
        end else if (take) begin
            if (phase_hi) hi_q <= din;
            else          lo_q <= din;
            phase_hi <= ~phase_hi;
        end
    end

    assign word     = {hi_q, lo_q};
    assign word_vld = take & phase_hi;

endmodule

// File: rtl/bootram_loader.sv
// Boot RAM loader: packs a byte stream into words written from base_addr upward,
// with a running checksum. Define BOOTRAM_LOADER_READBACK_EN to read back each word.
module bootram_loader
    import bootram_pkg::*;
#(
    parameter int ADDR = BOOTRAM_ADDR,
    parameter int DATA = BOOTRAM_DATA
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [ADDR-1:0]  base_addr,
    input  logic [ADDR:0]    length,
    bootram_loader_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      checksum
);

    state_t          st, nxt;
    logic [ADDR-1:0] addr;
    logic [ADDR-1:0] addr_q;
    logic [ADDR:0]   remaining;
    logic [DATA-1:0] wdata_q;
    word_t           word;
    logic            pk_vld;
    logic            fire;
    logic            accept;
    logic            s_ready;
    logic            ram_ce;
    logic            ram_we;

    assign s_ready = (st == LO) || (st == HI);
    assign fire    = bus.s_valid & s_ready;
    assign accept  = (st == IDLE) & start;

    bootram_pack16 u_pack (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (accept),
        .take     (fire),
        .din      (bus.s_data),
        .word     (word),
        .word_vld (pk_vld)
    );

`ifdef BOOTRAM_LOADER_READBACK_EN
    logic mismatch;
    assign mismatch = (bus.ram_rdata != word);
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.ram_rdata;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= IDLE;
        else       st <= nxt;
    end

    always_comb begin
        nxt    = st;
        ram_ce = 1'b0;
        ram_we = 1'b0;
        case (st)
            IDLE:   if (start) nxt = (length == '0) ? DONE : LO;
            LO:     if (fire) nxt = HI;
            HI:     if (pk_vld) nxt = WRITE;
`ifdef BOOTRAM_LOADER_READBACK_EN
            WRITE: begin
                ram_ce = 1'b1;
                ram_we = 1'b1;
                nxt    = VERIFY;
            end
            VERIFY: begin
                ram_ce = 1'b1;
                nxt    = CHECK;
            end
            CHECK:  nxt = mismatch ? DONE : NEXT;
`else
            WRITE: begin
                ram_ce = 1'b1;
                ram_we = 1'b1;
                nxt    = NEXT;
            end
`endif
            NEXT:   nxt = (remaining == '0) ? DONE : LO;
            DONE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Address counter, word count, checksum and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr      <= '0;
            addr_q    <= '0;
            remaining <= '0;
            wdata_q   <= '0;
            checksum  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    addr      <= base_addr;
                    remaining <= length;
                    checksum  <= '0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b1;
                end
                WRITE: begin
                    checksum  <= checksum + word;
                    remaining <= remaining - (ADDR+1)'(1);
                    addr_q    <= addr;
                    wdata_q   <= word;
                end
`ifdef BOOTRAM_LOADER_READBACK_EN
                CHECK: if (mismatch) err <= 1'b1;
`endif
                NEXT: addr <= addr + ADDR'(1);
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RAM address/data track the live values while the port is in use, then hold
    assign bus.s_ready   = s_ready;
    assign bus.ram_ce    = ram_ce;
    assign bus.ram_we    = ram_we;
    assign bus.ram_addr  = (st == WRITE || st == VERIFY) ? addr : addr_q;
    assign bus.ram_wdata = (st == WRITE) ? word : wdata_q;

endmodule

// File: tb/tb_bootram_loader.sv
// Bench for bootram_loader: table vectors, corner-case sequences and randomized
// transfers checked against a word-list/checksum model and a RAM model.
module tb_bootram_loader;
    import bootram_pkg::*;

    localparam int A = BOOTRAM_ADDR;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [A-1:0]  base_addr;
    logic [A:0]    length;
    logic          busy, done, err;
    logic [15:0]   checksum;

    bootram_loader_if bif ();

    bootram_loader dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .bus       (bif),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // RAM model with registered read address and write log
    logic [15:0]  mem [0:(1<<A)-1];
    logic [15:0]  rd_q;
    bit           inject;
    logic [A-1:0] wl_a [$];
    logic [15:0]  wl_d [$];
    int           nacc   = 0;
    int           nready = 0;

    assign bif.ram_rdata = rd_q;

    always @(posedge clk) begin
        if (bif.ram_ce)
            rd_q <= (inject && mem[bif.ram_addr] == 16'hBEEF) ? 16'hDEAD : mem[bif.ram_addr];
        if (bif.ram_ce && bif.ram_we) begin
            mem[bif.ram_addr] <= bif.ram_wdata;
            wl_a.push_back(bif.ram_addr);
            wl_d.push_back(bif.ram_wdata);
        end
        if (bif.s_valid && bif.s_ready) nacc <= nacc + 1;
        if (bif.s_ready) nready <= nready + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] bq [$];

    task automatic load_bq(input logic [63:0] v, input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(v[8*i +: 8]);
    endtask

    task automatic pulse_start(input logic [A-1:0] b, input logic [A:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok          = 1'b0;
        bif.s_valid = 1'b0;
        bif.s_data  = 8'h5A;
        repeat (gap) @(negedge clk);
        bif.s_data  = b;
        bif.s_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bif.s_ready) ok = 1'b1;
            @(negedge clk);
        end
        bif.s_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (done && !busy) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    // Model: word i = {byte 2i+1, byte 2i} at (base+i) mod 2^A; checksum = sum mod 2^16
    task automatic run_xfer(input string nm, input logic [A-1:0] b, input int len,
                            input int maxgap, output int w0);
        int           a0;
        bit           ok;
        logic [15:0]  ck;
        logic [15:0]  w;
        logic [A-1:0] ea;
        w0 = wl_a.size();
        a0 = nacc;
        ck = 16'h0;
        pulse_start(b, (A+1)'(len));
        chk({nm, "_start"}, {busy, done, err}, 3'b100);
        for (int i = 0; i < 2*len; i++) begin
            send_byte(bq[i], int'($urandom_range(maxgap, 0)), ok);
            if (!ok) begin
                chk({nm, "_byte_accept"}, ok, 1);
                break;
            end
        end
        wait_done(ok);
        chk({nm, "_done"}, ok, 1);
        chk({nm, "_nwrites"}, wl_a.size() - w0, len);
        chk({nm, "_nbytes"}, nacc - a0, 2*len);
        for (int i = 0; i < len; i++) begin
            w  = {bq[2*i+1], bq[2*i]};
            ck = ck + w;
            ea = b + A'(i);
            if (w0 + i < wl_a.size()) begin
                chk($sformatf("%s_addr%0d", nm, i), wl_a[w0+i], ea);
                chk($sformatf("%s_data%0d", nm, i), wl_d[w0+i], w);
            end
        end
        chk({nm, "_checksum"}, checksum, ck);
        chk({nm, "_err"}, err, 0);
    endtask

    typedef struct packed {
        logic [A-1:0]       base;
        int                 len;
        logic [31:0]        bytes;
        logic [1:0][A-1:0]  ea;
        logic [1:0][15:0]   ed;
        logic [15:0]        eck;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int           w0, r0, len;
        bit           ok;
        logic [A-1:0] b;

        tbl[0] = '{base: 13'h0000, len: 2, bytes: 32'h5678_1234,
                   ea: {13'h0001, 13'h0000}, ed: {16'h5678, 16'h1234}, eck: 16'h68AC};
        tbl[1] = '{base: 13'h1FFF, len: 2, bytes: 32'h0002_0001,
                   ea: {13'h0000, 13'h1FFF}, ed: {16'h0002, 16'h0001}, eck: 16'h0003};
        tbl[2] = '{base: 13'h0100, len: 1, bytes: 32'h0000_FFFF,
                   ea: {13'h0000, 13'h0100}, ed: {16'h0000, 16'hFFFF}, eck: 16'hFFFF};
        tbl[3] = '{base: 13'h0ABC, len: 2, bytes: 32'h0002_FFFF,
                   ea: {13'h0ABD, 13'h0ABC}, ed: {16'h0002, 16'hFFFF}, eck: 16'h0001};

        rstn = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        bif.s_valid = 1'b0; bif.s_data = 8'h00; inject = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_ctrl", {bif.s_ready, bif.ram_ce, bif.ram_we, busy, done, err}, 6'b0);
        chk("rst_addr", bif.ram_addr, 0);
        chk("rst_wdata", bif.ram_wdata, 0);
        chk("rst_checksum", checksum, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            load_bq(64'(tbl[k].bytes), 4);
            run_xfer($sformatf("tbl%0d", k), tbl[k].base, tbl[k].len, 1, w0);
            for (int j = 0; j < tbl[k].len; j++) begin
                if (w0 + j < wl_a.size()) begin
                    chk($sformatf("tbl%0d_vaddr%0d", k, j), wl_a[w0+j], tbl[k].ea[j]);
                    chk($sformatf("tbl%0d_vdata%0d", k, j), wl_d[w0+j], tbl[k].ed[j]);
                end
            end
            chk($sformatf("tbl%0d_vck", k), checksum, tbl[k].eck);
        end

        // length 0, start held into the DONE cycle (that second sample must be ignored)
        w0 = wl_a.size(); r0 = nready;
        base_addr = 13'h0123; length = '0; start = 1'b1;
        @(negedge clk);
        length = 14'd3;
        chk("len0_c1", {busy, done}, 2'b10);
        @(negedge clk);
        start = 1'b0;
        chk("len0_c2", {busy, done}, 2'b01);
        @(negedge clk); @(negedge clk);
        chk("len0_hold", {busy, done}, 2'b01);
        chk("len0_nwrites", wl_a.size() - w0, 0);
        chk("len0_ready", nready - r0, 0);

        // valid pattern 1,0,0,1 with a start pulse while busy
        w0 = wl_a.size(); r0 = nacc;
        pulse_start(13'h0200, 14'd1);
        bif.s_valid = 1'b1; bif.s_data = 8'hAA;
        @(negedge clk);
        bif.s_valid = 1'b0; bif.s_data = 8'hCC;
        base_addr = 13'h0777; length = 14'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bif.s_valid = 1'b1; bif.s_data = 8'hBB;
        @(negedge clk);
        bif.s_valid = 1'b0;
        wait_done(ok);
        chk("stall_done", ok, 1);
        chk("stall_nbytes", nacc - r0, 2);
        chk("stall_nwrites", wl_a.size() - w0, 1);
        if (wl_a.size() > w0) begin
            chk("stall_addr", wl_a[w0], 13'h0200);
            chk("stall_data", wl_d[w0], 16'hBBAA);
        end
        chk("stall_checksum", checksum, 16'hBBAA);

        // reset while in HI of word 3 of 5
        w0 = wl_a.size();
        load_bq(64'h05_0403_0201, 5);
        pulse_start(13'h0300, 14'd5);
        for (int i = 0; i < 5; i++) send_byte(bq[i], 0, ok);
        chk("mrst_hi_ready", bif.s_ready, 1);
        chk("mrst_nwrites", wl_a.size() - w0, 2);
        rstn = 1'b0;
        #1;
        chk("mrst_ctrl", {bif.s_ready, bif.ram_ce, bif.ram_we, busy, done, err}, 6'b0);
        chk("mrst_addr", bif.ram_addr, 0);
        chk("mrst_wdata", bif.ram_wdata, 0);
        chk("mrst_checksum", checksum, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        load_bq(64'hA55A, 2);
        run_xfer("post_rst", 13'h0301, 1, 1, w0);

        // readback corrupting 0xBEEF into 0xDEAD
        inject = 1'b1;
`ifdef BOOTRAM_LOADER_READBACK_EN
        w0 = wl_a.size();
        pulse_start(13'h0040, 14'd3);
        send_byte(8'hEF, 0, ok);
        send_byte(8'hBE, 0, ok);
        wait_done(ok);
        chk("rb_done", ok, 1);
        chk("rb_err", err, 1);
        chk("rb_nwrites", wl_a.size() - w0, 1);
        if (wl_a.size() > w0) chk("rb_data", wl_d[w0], 16'hBEEF);
        send_byte(8'h11, 0, ok);
        chk("rb_no_ready", ok, 0);
        inject = 1'b0;
        load_bq(64'h1234, 2);
        run_xfer("rb_clear", 13'h0041, 1, 0, w0);
`else
        load_bq(64'h0002_0001_BEEF, 6);
        run_xfer("rb_off", 13'h0040, 3, 1, w0);
        inject = 1'b0;
`endif

        for (int k = 0; k < 16; k++) begin
            len = int'($urandom_range(6, 1));
            if (k % 4 == 0) b = A'((1 << A) - 1 - int'($urandom_range(2, 0)));
            else            b = A'($urandom);
            bq.delete();
            for (int i = 0; i < 2*len; i++) bq.push_back(8'($urandom));
            run_xfer($sformatf("rnd%0d", k), b, len, 3, w0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
